apb_master_fsm: RTL
===================

Name: apb_master_fsm

Overview:
- APB requester (initiator) that turns a simple valid/ready command interface into compliant APB SETUP/ACCESS transfers.
- Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA to a single APB completer such as apb_slave_fsm.
- Returns read data, PSLVERR and a wait-state timeout flag on a one-cycle response strobe.
- Sits between the internal control logic and the peripheral register bus.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata.
- ADDR_WIDTH, 32, width of PADDR/cmd_addr.
- TIMEOUT, 16, number of consecutive ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESET  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on the edge where cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  1 when the transfer was aborted by timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset values:
  - state=IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0.
  - wait counter = 0.
  - All APB outputs and rsp_* are registered.
- States: IDLE, SETUP, ACCESS.
- cmd_ready (combinational) = (state==IDLE) | (state==ACCESS & PREADY). It is never asserted in SETUP. It is held 0 while PRESET=1.
- IDLE:
  - PSEL=0, PENABLE=0.
  - On accept: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA (PWDATA=0 for reads); PSEL=1, PENABLE=0; go SETUP.
  - With no accept, PADDR/PWRITE hold their last values.
- SETUP: lasts exactly one cycle. Next edge sets PENABLE=1 and goes ACCESS; PADDR/PWRITE/PWDATA are unchanged.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable until the edge on which PREADY=1 is sampled.
  - Completion (PREADY=1 sampled):
    - rsp_valid=1 for exactly one cycle.
    - rsp_err=PSLVERR; rsp_timeout=0.
    - rsp_rdata=PRDATA for reads, 0 for writes.
    - PSLVERR is ignored unless PREADY=1.
  - Back-to-back: if a command is also accepted on the completion edge, go directly to SETUP with the new command (PSEL stays 1, PENABLE=0). Otherwise go IDLE with PSEL=0, PENABLE=0.
  - Wait states: each ACCESS cycle with PREADY=0 increments the wait counter. The counter clears on entry to SETUP.
  - Timeout (TIMEOUT>0): when the counter reaches TIMEOUT with PREADY still 0:
    - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - PSEL=0, PENABLE=0; go IDLE.
    - No command is accepted on the timeout edge.
  - TIMEOUT=0: wait indefinitely.
- Latency:
  - Zero-wait transfer: accept edge to rsp_valid is 2 edges (SETUP, ACCESS).
  - Each PREADY=0 cycle adds 1.
  - Back-to-back zero-wait throughput is one transfer per 2 cycles.
- rsp_valid and rsp_timeout are single-cycle pulses. rsp_rdata and rsp_err hold their values until the next response.
- Reset mid-transfer: PSEL/PENABLE drop to 0 asynchronously, rsp_valid stays 0, and no response is ever produced for the aborted transfer. After reset release the block is in IDLE.
- Counter width is sized to hold TIMEOUT (minimum 1 bit). Counter saturation is not reachable because the timeout aborts first.

Test Plan:
- Write/read valid registers: with apb_slave_fsm (4 regs), write 0x11111111..0x44444444 to 0x00, 0x04, 0x08, 0x0C, then read them back. Required: each rsp_rdata matches, rsp_err=0. PSEL high for exactly 2 cycles per transfer, PENABLE low in the first cycle and high in the second.
- Invalid address: write 0xDEADBEEF to 0x10, then read 0x20. Required: rsp_err=1, rsp_timeout=0, read rsp_rdata reported as returned with rsp_valid one cycle.
- Back-to-back: cmd_valid held high for 3 writes (0x00, 0x04, 0x08). Required: PSEL stays 1 continuously for 6 cycles, PENABLE toggles 0,1,0,1,0,1, 3 rsp_valid pulses spaced 2 cycles apart.
- Wait states: stub completer holds PREADY=0 for 3 ACCESS cycles on a read returning 0xA5A5A5A5. Required: PADDR/PWRITE stable throughout, rsp_valid 5 edges after accept, rsp_rdata=0xA5A5A5A5.
- Timeout (TIMEOUT=4): stub never asserts PREADY. Required: after 4 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; next cycle PSEL=0 and cmd_ready=1.
- Reset mid-ACCESS: assert PRESET while PREADY=0. Required: PSEL/PENABLE go 0 immediately, no rsp_valid. After release, a write to 0x04 of 0x5A5A5A5A completes normally.

Source files
------------

// File: rtl/apb_master_fsm.sv
// APB requester: turns a valid/ready command into APB SETUP/ACCESS transfers
// and reports completion, slave error and wait-state timeout on a response strobe.
module apb_master_fsm #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             done;
    logic             expire;

    assign cmd_ready = !PRESET && ((state == IDLE) || (state == ACCESS && PREADY));
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && PREADY;
    // Abort on the edge that would record the TIMEOUT-th stalled ACCESS cycle.
    assign expire    = (TIMEOUT != 0) && (state == ACCESS) && !PREADY && (wait_cnt == LAST_WAIT);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (done) state_next = accept ? SETUP : IDLE;
                else if (expire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            wait_cnt    <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            if (state == SETUP) begin
                PENABLE <= 1'b1;
            end
            if (done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= PSLVERR;
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                PSEL      <= 1'b0;
                PENABLE   <= 1'b0;
            end
            if (expire) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= '0;
                PSEL        <= 1'b0;
                PENABLE     <= 1'b0;
            end else if (TIMEOUT != 0 && state == ACCESS && !PREADY) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // A back-to-back accept overrides the completion's bus release.
            if (accept) begin
                PSEL     <= 1'b1;
                PENABLE  <= 1'b0;
                PWRITE   <= cmd_write;
                PADDR    <= cmd_addr;
                PWDATA   <= cmd_write ? cmd_wdata : '0;
                wait_cnt <= '0;
            end
        end
    end

endmodule
